// File: rtl/decode_stage_sequencer.sv
// decode_stage_sequencer: top-level phase sequencer for the image decompressor.
// Runs UART load -> enabled processing stages in ascending index order -> VGA
// display, and owns the single SRAM port, muxing address / write-enable /
// write-data from whichever phase currently holds it.
// Optional feature: define STAGE_WATCHDOG_EN to add a per-stage cycle watchdog
// with a sticky wdog_error flag; without it a stage may run indefinitely.
module decode_stage_sequencer #(
   parameter int unsigned NUM_STAGES   = 2,
   parameter int unsigned ADDR_W       = 18,
   parameter int unsigned DATA_W       = 16,
   parameter int unsigned UART_TIMEOUT = 50000000,
   parameter int unsigned WDOG_CYCLES  = 16777215
) (
   input  logic                         CLOCK_50_I,
   input  logic                         resetn,
   input  logic                         uart_rx_i,
   input  logic                         uart_sram_we_n,
   input  logic [ADDR_W-1:0]            uart_addr,
   input  logic [DATA_W-1:0]            uart_wdata,
   output logic                         uart_init,
   output logic                         uart_enable,
   input  logic [ADDR_W-1:0]            vga_addr,
   output logic                         vga_enable,
   input  logic [NUM_STAGES-1:0]        stage_en,
   output logic [NUM_STAGES-1:0]        stage_start,
   input  logic [NUM_STAGES-1:0]        stage_done,
   input  logic [NUM_STAGES*ADDR_W-1:0] stage_addr,
   input  logic [NUM_STAGES-1:0]        stage_we_n,
   input  logic [NUM_STAGES*DATA_W-1:0] stage_wdata,
   output logic [ADDR_W-1:0]            sram_addr,
   output logic                         sram_we_n,
   output logic [DATA_W-1:0]            sram_wdata,
   output logic [2:0]                   active_stage,
   output logic                         busy,
   output logic [7:0]                   frame_count,
   output logic                         wdog_error
);

   localparam int unsigned TIMER_W = 26;
   localparam int unsigned WDOG_W  = 24;
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(UART_TIMEOUT - 1);

   if (NUM_STAGES < 1 || NUM_STAGES > 8) begin : g_bad_num_stages
      $error("decode_stage_sequencer: NUM_STAGES must be in 1..8");
   end
   if (UART_TIMEOUT < 1 || UART_TIMEOUT > (1 << TIMER_W)) begin : g_bad_timeout
      $error("decode_stage_sequencer: UART_TIMEOUT does not fit the 26-bit timer");
   end
   if (WDOG_CYCLES < 1 || WDOG_CYCLES > ((1 << WDOG_W) - 1)) begin : g_bad_wdog
      $error("decode_stage_sequencer: WDOG_CYCLES does not fit the 24-bit counter");
   end

   typedef enum logic [1:0] {S_IDLE, S_UART_RX, S_RUN} state_t;
   typedef struct packed {
      logic       found;
      logic [2:0] idx;
   } pick_t;

   // Lowest enabled stage with index >= lo.
   function automatic pick_t pick_from(input logic [NUM_STAGES-1:0] mask, input int lo);
      pick_t p;
      p = '0;
      for (int k = int'(NUM_STAGES) - 1; k >= 0; k--) begin
         if (k >= lo && mask[k]) begin
            p.found = 1'b1;
            p.idx   = 3'(k);
         end
      end
      return p;
   endfunction

   state_t                  state_q, state_d;
   logic [2:0]              idx_q, idx_d;
   logic [NUM_STAGES-1:0]   mask_q, mask_d;
   logic [TIMER_W-1:0]      timer_q, timer_d;
   logic [7:0]              frame_q, frame_d;
   logic                    uart_init_q, uart_init_d;
   logic                    uart_enable_q;
   logic                    vga_enable_q, vga_enable_d;
   logic [NUM_STAGES-1:0]   stage_start_q, stage_start_d;
`ifdef STAGE_WATCHDOG_EN
   logic [WDOG_W-1:0]       wdog_q, wdog_d;
   logic                    wdog_err_q, wdog_err_d;
   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);
`endif

   logic [ADDR_W-1:0]       sel_addr;
   logic [DATA_W-1:0]       sel_wdata;
   logic                    sel_we_n;
   logic                    sel_done;
   logic                    sel_start;
   pick_t                   first_pick, next_pick;

   // Pick out the signals of the stage currently indexed by idx_q.
   always_comb begin
      // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
      sel_addr  = '0;
      sel_wdata = '0;
      sel_we_n  = 1'b1;
      sel_done  = 1'b0;
      sel_start = 1'b0;
      for (int k = 0; k < int'(NUM_STAGES); k++) begin
         if (idx_q == 3'(k)) begin
            sel_addr  = stage_addr[k*ADDR_W +: ADDR_W];
            sel_wdata = stage_wdata[k*DATA_W +: DATA_W];
            sel_we_n  = stage_we_n[k];
            sel_done  = stage_done[k];
            sel_start = stage_start_q[k];
         end
      end
   end

   // Next-state, timer, frame counter and registered-output decode.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      mask_d      = mask_q;
      timer_d     = timer_q;
      frame_d     = frame_q;
      uart_init_d = 1'b0;
`ifdef STAGE_WATCHDOG_EN
      wdog_d      = wdog_q;
      wdog_err_d  = wdog_err_q;
`endif
      first_pick  = pick_from(mask_q, 0);
      next_pick   = pick_from(mask_q, int'(idx_q) + 1);

      case (state_q)
         S_IDLE: begin
            if (!uart_rx_i) begin
               state_d     = S_UART_RX;
               uart_init_d = 1'b1;
               timer_d     = '0;
               mask_d      = stage_en;
`ifdef STAGE_WATCHDOG_EN
               wdog_err_d  = 1'b0;
`endif
            end
         end
         S_UART_RX: begin
            // Any write restarts the silence window; a write wins over the timeout.
            if (!uart_sram_we_n) begin
               timer_d = '0;
            end else if (timer_q == TIMER_LAST) begin
               if (first_pick.found) begin
                  state_d = S_RUN;
                  idx_d   = first_pick.idx;
`ifdef STAGE_WATCHDOG_EN
                  wdog_d  = '0;
`endif
               end else begin
                  state_d = S_IDLE;
                  frame_d = frame_q + 8'd1;
               end
            end else if (timer_q != '1) begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_RUN: begin
            // Only the running stage's done counts, and only while its start is up.
            if (sel_start && sel_done) begin
               if (next_pick.found) begin
                  idx_d   = next_pick.idx;
`ifdef STAGE_WATCHDOG_EN
                  wdog_d  = '0;
`endif
               end else begin
                  state_d = S_IDLE;
                  frame_d = frame_q + 8'd1;
               end
            end
`ifdef STAGE_WATCHDOG_EN
            else if (wdog_q == WDOG_LAST) begin
               state_d    = S_IDLE;
               wdog_err_d = 1'b1;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
`endif
         end
         default: state_d = S_IDLE;
      endcase

      vga_enable_d = (state_d == S_IDLE);
      for (int k = 0; k < int'(NUM_STAGES); k++) begin
         stage_start_d[k] = (state_d == S_RUN) && (idx_d == 3'(k));
      end
   end

   // State and registered outputs; async reset drops any running stage's start at once.
   always_ff @(posedge CLOCK_50_I or negedge resetn) begin
      if (!resetn) begin
         state_q       <= S_IDLE;
         idx_q         <= '0;
         mask_q        <= '0;
         timer_q       <= '0;
         frame_q       <= '0;
         uart_init_q   <= 1'b0;
         uart_enable_q <= 1'b0;
         vga_enable_q  <= 1'b1;
         stage_start_q <= '0;
`ifdef STAGE_WATCHDOG_EN
         wdog_q        <= '0;
         wdog_err_q    <= 1'b0;
`endif
      end else begin
         // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
         state_q       <= state_d;
         idx_q         <= idx_d;
         mask_q        <= mask_d;
         timer_q       <= timer_d;
         frame_q       <= frame_d;
         uart_init_q   <= uart_init_d;
         uart_enable_q <= uart_init_q;
         vga_enable_q  <= vga_enable_d;
         stage_start_q <= stage_start_d;
`ifdef STAGE_WATCHDOG_EN
         wdog_q        <= wdog_d;
         wdog_err_q    <= wdog_err_d;
`endif
      end
   end

   // SRAM port mux, driven from the registered phase so it never glitches on inputs.
   always_comb begin
      sram_addr  = vga_addr;
      sram_we_n  = 1'b1;
      sram_wdata = '0;
      case (state_q)
         S_UART_RX: begin
            sram_addr  = uart_addr;
            sram_we_n  = uart_sram_we_n;
            sram_wdata = uart_wdata;
         end
         S_RUN: begin
            sram_addr  = sel_addr;
            sram_we_n  = sel_we_n;
            sram_wdata = sel_wdata;
         end
         default: ;
      endcase
   end

   assign uart_init    = uart_init_q;
   assign uart_enable  = uart_enable_q;
   assign vga_enable   = vga_enable_q;
   assign stage_start  = stage_start_q;
   assign active_stage = (state_q == S_RUN) ? idx_q : 3'd0;
   assign busy         = (state_q != S_IDLE);
   assign frame_count  = frame_q;
`ifdef STAGE_WATCHDOG_EN
   assign wdog_error   = wdog_err_q;
`else
   assign wdog_error   = 1'b0;
`endif

endmodule

// File: tb/tb_decode_stage_sequencer.sv
// Bench for decode_stage_sequencer: NUM_STAGES=2, UART_TIMEOUT=100, WDOG_CYCLES=50.
// Expected stage starts are queued when a frame is launched and popped as the
// DUT raises each stage_start; the watchdog scenario runs when STAGE_WATCHDOG_EN is defined.
module tb_decode_stage_sequencer;

   localparam int NS = 2;
   localparam int AW = 18;
   localparam int DW = 16;
   localparam int TO = 100;
   localparam int WD = 50;
   localparam logic [AW-1:0] VGA_A = 18'h30F0F;

   logic             clk;
   logic             resetn;
   logic             uart_rx_i;
   logic             uart_sram_we_n;
   logic [AW-1:0]    uart_addr;
   logic [DW-1:0]    uart_wdata;
   logic             uart_init;
   logic             uart_enable;
   logic [AW-1:0]    vga_addr;
   logic             vga_enable;
   logic [NS-1:0]    stage_en;
   logic [NS-1:0]    stage_start;
   logic [NS-1:0]    stage_done;
   logic [NS*AW-1:0] stage_addr;
   logic [NS-1:0]    stage_we_n;
   logic [NS*DW-1:0] stage_wdata;
   logic [AW-1:0]    sram_addr;
   logic             sram_we_n;
   logic [DW-1:0]    sram_wdata;
   logic [2:0]       active_stage;
   logic             busy;
   logic [7:0]       frame_count;
   logic             wdog_error;

   logic [AW-1:0]    s_addr  [NS];
   logic [DW-1:0]    s_wdata [NS];
   logic [NS-1:0]    s_we_n;

   int total = 0;
   int bad   = 0;
   int exp_q[$];
   int exp_frames = 0;

   decode_stage_sequencer #(
      .NUM_STAGES  (NS),
      .ADDR_W      (AW),
      .DATA_W      (DW),
      .UART_TIMEOUT(TO),
      .WDOG_CYCLES (WD)
   ) dut (
      .CLOCK_50_I    (clk),
      .resetn        (resetn),
      .uart_rx_i     (uart_rx_i),
      .uart_sram_we_n(uart_sram_we_n),
      .uart_addr     (uart_addr),
      .uart_wdata    (uart_wdata),
      .uart_init     (uart_init),
      .uart_enable   (uart_enable),
      .vga_addr      (vga_addr),
      .vga_enable    (vga_enable),
      .stage_en      (stage_en),
      .stage_start   (stage_start),
      .stage_done    (stage_done),
      .stage_addr    (stage_addr),
      .stage_we_n    (stage_we_n),
      .stage_wdata   (stage_wdata),
      .sram_addr     (sram_addr),
      .sram_we_n     (sram_we_n),
      .sram_wdata    (sram_wdata),
      .active_stage  (active_stage),
      .busy          (busy),
      .frame_count   (frame_count),
      .wdog_error    (wdog_error)
   );

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic wait_start(output int n);
      n = 0;
      while (stage_start == '0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("start_seen", 32'(stage_start != '0), 1);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("idle_reached", 32'(busy), 0);
   endtask

   // Leave IDLE, check the init/enable pulses, then perform nwrites UART writes.
   task automatic load_phase(input logic [NS-1:0] mask, input int nwrites);
      @(negedge clk);
      uart_rx_i = 1'b0;
      stage_en  = mask;
      @(negedge clk);
      check("busy_rise",         32'(busy),        1);
      check("uart_init_pulse",   32'(uart_init),   1);
      check("uart_enable_early", 32'(uart_enable), 0);
      check("wdog_clear",        32'(wdog_error),  0);
      check("vga_off",           32'(vga_enable),  0);
      stage_en = ~mask;   // mask must already be latched
      @(negedge clk);
      check("uart_init_fall",    32'(uart_init),   0);
      check("uart_enable_pulse", 32'(uart_enable), 1);
      for (int w = 0; w < nwrites; w++) begin
         @(negedge clk);
         uart_sram_we_n = 1'b0;
         uart_addr      = AW'(32'h2000 + w);
         uart_wdata     = DW'(32'hA500 + w);
         #1;
         check("uart_mux_addr",  32'(sram_addr),  32'h2000 + w);
         check("uart_mux_we",    32'(sram_we_n),  0);
         check("uart_mux_wdata", 32'(sram_wdata), 32'hA500 + w);
         @(negedge clk);
         uart_sram_we_n = 1'b1;
      end
      uart_rx_i = 1'b1;
   endtask

   task automatic run_frame(input logic [NS-1:0] mask, input int nwrites,
                            input bit inject, input int reset_stage);
      int n;
      int e;
      bit first;
      bit saw_start;
      first = 1'b1;
      load_phase(mask, nwrites);
      for (int k = 0; k < NS; k++) if (mask[k]) exp_q.push_back(k);

      if (exp_q.size() == 0) begin
         saw_start = 1'b0;
         n = 0;
         while (busy && n < 300) begin
            @(negedge clk);
            n++;
            if (stage_start != '0) saw_start = 1'b1;
         end
         check("empty_mask_idle",     32'(busy),      0);
         check("empty_mask_no_start", 32'(saw_start), 0);
         exp_frames++;
         check("frame_count_empty", 32'(frame_count), 32'(exp_frames % 256));
         check("vga_back_empty",    32'(vga_enable),  1);
         return;
      end

      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         wait_start(n);
         if (first && nwrites > 0) check("timeout_cycles", 32'(n), TO);
         else if (!first)          check("done_to_start",  32'(n), 0);
         first = 1'b0;
         check("start_onehot", 32'(stage_start),  32'(1 << e));
         check("active_stage", 32'(active_stage), 32'(e));
         check("run_addr",     32'(sram_addr),    32'(s_addr[e]));
         check("run_wdata",    32'(sram_wdata),   32'(s_wdata[e]));
         check("run_we",       32'(sram_we_n),    32'(s_we_n[e]));
         if (inject && e == 0) begin
            stage_done[1] = 1'b1;
            @(negedge clk);
            stage_done[1] = 1'b0;
            check("foreign_done_start", 32'(stage_start),  32'h1);
            check("foreign_done_act",   32'(active_stage), 0);
            check("foreign_done_addr",  32'(sram_addr),    32'(s_addr[0]));
            @(negedge clk);
            check("foreign_done_hold",  32'(stage_start),  32'h1);
         end
         if (e == reset_stage) begin
            @(negedge clk);
            resetn = 1'b0;
            #1;
            check("rst_start", 32'(stage_start),  0);
            check("rst_vga",   32'(vga_enable),   1);
            check("rst_frame", 32'(frame_count),  0);
            check("rst_busy",  32'(busy),         0);
            check("rst_act",   32'(active_stage), 0);
            check("rst_we",    32'(sram_we_n),    1);
            exp_frames = 0;
            exp_q.delete();
            @(negedge clk);
            resetn = 1'b1;
            return;
         end
         repeat (2 + e) @(negedge clk);
         check("start_held", 32'(stage_start), 32'(1 << e));
         stage_done[e] = 1'b1;
         @(negedge clk);
         check("start_fall", 32'(stage_start[e]), 0);
         stage_done[e] = 1'b0;
      end
      exp_frames++;
      check("frame_count", 32'(frame_count),  32'(exp_frames % 256));
      check("vga_back",    32'(vga_enable),   1);
      check("idle_busy",   32'(busy),         0);
      check("idle_act",    32'(active_stage), 0);
      check("idle_we",     32'(sram_we_n),    1);
      check("idle_addr",   32'(sram_addr),    32'(VGA_A));
   endtask

   assign stage_addr  = {s_addr[1], s_addr[0]};
   assign stage_wdata = {s_wdata[1], s_wdata[0]};
   assign stage_we_n  = s_we_n;

   initial begin
      int n;
      s_addr[0]  = 18'h00AAA;
      s_addr[1]  = 18'h01555;
      s_wdata[0] = 16'h1111;
      s_wdata[1] = 16'h2222;
      s_we_n     = 2'b10;
      resetn         = 1'b0;
      uart_rx_i      = 1'b1;
      uart_sram_we_n = 1'b1;
      uart_addr      = '0;
      uart_wdata     = '0;
      vga_addr       = VGA_A;
      stage_en       = '0;
      stage_done     = '0;

      repeat (2) @(negedge clk);
      check("reset_busy",   32'(busy),         0);
      check("reset_vga",    32'(vga_enable),   1);
      check("reset_start",  32'(stage_start),  0);
      check("reset_frame",  32'(frame_count),  0);
      check("reset_init",   32'(uart_init),    0);
      check("reset_enable", 32'(uart_enable),  0);
      check("reset_wdog",   32'(wdog_error),   0);
      check("reset_we",     32'(sram_we_n),    1);
      check("reset_addr",   32'(sram_addr),    32'(VGA_A));
      check("reset_wdata",  32'(sram_wdata),   0);
      check("reset_act",    32'(active_stage), 0);
      @(negedge clk);
      resetn = 1'b1;

      run_frame(2'b11, 3, 1'b1, -1);   // full run, foreign done pulsed during RUN(0)
      run_frame(2'b10, 2, 1'b0, -1);   // stage 0 skipped
      run_frame(2'b00, 0, 1'b0, -1);   // empty mask
      run_frame(2'b11, 1, 1'b0, 1);    // reset asserted mid RUN(1)
      run_frame(2'b01, 0, 1'b0, -1);   // count restarts after reset

`ifdef STAGE_WATCHDOG_EN
      load_phase(2'b01, 0);
      wait_start(n);
      check("wdog_start", 32'(stage_start), 32'h1);
      n = 0;
      while (stage_start[0] && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("wdog_cycles", 32'(n),           WD);
      check("wdog_flag",   32'(wdog_error),  1);
      check("wdog_frame",  32'(frame_count), 32'(exp_frames % 256));
      check("wdog_idle",   32'(busy),        0);
      check("wdog_vga",    32'(vga_enable),  1);
      load_phase(2'b00, 0);              // wdog_error must clear on entry to UART_RX
      wait_idle();
      exp_frames++;
      check("wdog_next_frame", 32'(frame_count), 32'(exp_frames % 256));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
